data_ring_que: RTL and testbench

Parametrised in-order ring buffer for side data held during dispatch, such as immediates, PCs and predicted-taken PCs.
- Accepts up to INPORT_NUM sparse enqueue requests per cycle and returns an index for each.
- Serves random reads by index and records writeback completion per entry.
- Retires up to CLEAR_WID completed entries per cycle strictly from the head, and reports which indices it freed.
- Supports squash (tail rollback to a given index) and full flush for backend redirect.

---
 rtl/data_ring_que_if.sv | 62 ++++++
 rtl/data_ring_que.sv | 169 ++++++++++++++++
 tb/tb_data_ring_que.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_ring_que_if.sv
// Bundle of enqueue, read, writeback, redirect and retire signals for data_ring_que.
// Direction names follow the queue's point of view: i_* feed the queue, o_* come back out.
interface data_ring_que_if #(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned INPORT_NUM   = 4,
  parameter int unsigned READPORT_NUM = 4,
  parameter int unsigned WBPORT_NUM   = 4,
  parameter int unsigned CLEAR_WID    = 4,
  parameter type         dtype        = logic [31:0]
);
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic                  o_can_enq;
  logic [INPORT_NUM-1:0] i_enq_req;
  dtype                  i_enq_data    [INPORT_NUM];
  logic [IDXW-1:0]       o_alloc_id    [INPORT_NUM];
  logic [IDXW-1:0]       i_read_dqIdx  [READPORT_NUM];
  dtype                  o_read_data   [READPORT_NUM];
  logic [WBPORT_NUM-1:0] i_wb_vld;
  logic [IDXW-1:0]       i_wb_dqIdx    [WBPORT_NUM];
  logic                  i_squash_vld;
  logic [IDXW-1:0]       i_squash_dqIdx;
  logic                  i_flush;
  logic [CLEAR_WID-1:0]  o_clear_vld;
  logic [IDXW-1:0]       o_clear_dqIdx [CLEAR_WID];
  logic [CNTW-1:0]       o_count;

  modport slave (
    output o_can_enq,
    input  i_enq_req,
    input  i_enq_data,
    output o_alloc_id,
    input  i_read_dqIdx,
    output o_read_data,
    input  i_wb_vld,
    input  i_wb_dqIdx,
    input  i_squash_vld,
    input  i_squash_dqIdx,
    input  i_flush,
    output o_clear_vld,
    output o_clear_dqIdx,
    output o_count
  );

  modport master (
    input  o_can_enq,
    output i_enq_req,
    output i_enq_data,
    input  o_alloc_id,
    output i_read_dqIdx,
    input  o_read_data,
    output i_wb_vld,
    output i_wb_dqIdx,
    output i_squash_vld,
    output i_squash_dqIdx,
    output i_flush,
    input  o_clear_vld,
    input  o_clear_dqIdx,
    input  o_count
  );
endinterface

// File: rtl/data_ring_que.sv
// In-order ring buffer for dispatch side data: sparse multi-port enqueue, indexed reads,
// per-entry writeback completion, head-first multi-retire, tail squash and full flush.
module data_ring_que #(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned INPORT_NUM   = 4,
  parameter int unsigned READPORT_NUM = 4,
  parameter int unsigned WBPORT_NUM   = 4,
  parameter int unsigned CLEAR_WID    = 4,
  parameter type         dtype        = logic [31:0]
) (
  input logic            clk,
  input logic            rst,
  data_ring_que_if.slave io_bus
);
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  typedef logic [IDXW-1:0] idx_t;
  typedef logic [CNTW-1:0] cnt_t;

  // Modulo-DEPTH add; b never exceeds DEPTH so one subtraction suffices.
  function automatic idx_t f_add(input idx_t a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= DEPTH) s = s - DEPTH;
    return s[IDXW-1:0];
  endfunction

  function automatic int unsigned f_dist(input idx_t from, input idx_t to);
    int unsigned s;
    s = 32'(to) + DEPTH - 32'(from);
    if (s >= DEPTH) s = s - DEPTH;
    return s;
  endfunction

  dtype             r_buf [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_done;
  idx_t             r_head;
  idx_t             r_tail;
  cnt_t             r_count;

  logic [DEPTH-1:0]     w_vld_nxt;
  logic [DEPTH-1:0]     w_done_nxt;
  idx_t                 w_head_nxt;
  idx_t                 w_tail_nxt;
  cnt_t                 w_count_nxt;
  logic                 w_can_enq;
  logic                 w_accept;
  idx_t                 w_alloc_id [INPORT_NUM];
  int unsigned          w_enq_num;
  logic [CLEAR_WID-1:0] w_clear_vld;
  idx_t                 w_clear_idx [CLEAR_WID];
  int unsigned          w_clr_num;
  logic [DEPTH-1:0]     w_kill;
  int unsigned          w_sq_dist;

  // Enqueue: compact requesting ports onto consecutive slots starting at tail.
  always_comb begin
    w_enq_num = 0;
    for (int unsigned i = 0; i < INPORT_NUM; i++) begin
      w_alloc_id[i] = f_add(r_tail, w_enq_num);
      if (io_bus.i_enq_req[i]) w_enq_num = w_enq_num + 1;
    end
    w_can_enq = (32'(r_count) + INPORT_NUM) <= DEPTH;
    w_accept  = w_can_enq & (|io_bus.i_enq_req) & ~io_bus.i_squash_vld & ~io_bus.i_flush;
  end

  // Retire: contiguous run of valid+done entries from head, bounded by occupancy.
  always_comb begin
    logic chain;
    chain     = 1'b1;
    w_clr_num = 0;
    for (int unsigned k = 0; k < CLEAR_WID; k++) begin
      w_clear_idx[k] = f_add(r_head, k);
      chain = chain & (k < 32'(r_count)) & r_vld[w_clear_idx[k]] & r_done[w_clear_idx[k]];
      w_clear_vld[k] = chain & ~io_bus.i_flush;
      if (chain) w_clr_num = w_clr_num + 1;
    end
  end

  // Squash: kill every occupied entry at or beyond the squash point, measured from head.
  always_comb begin
    int unsigned d;
    w_sq_dist = f_dist(r_head, io_bus.i_squash_dqIdx);
    for (int unsigned e = 0; e < DEPTH; e++) begin
      d = f_dist(r_head, idx_t'(e));
      w_kill[e] = io_bus.i_squash_vld & (d >= w_sq_dist) & (d < 32'(r_count));
    end
  end

  always_comb begin
    w_vld_nxt  = r_vld;
    w_done_nxt = r_done;
    for (int unsigned j = 0; j < WBPORT_NUM; j++) begin
      if (io_bus.i_wb_vld[j] && (32'(io_bus.i_wb_dqIdx[j]) < DEPTH)
          && r_vld[io_bus.i_wb_dqIdx[j]]) begin
        w_done_nxt[io_bus.i_wb_dqIdx[j]] = 1'b1;
      end
    end
    for (int unsigned k = 0; k < CLEAR_WID; k++) begin
      if (w_clear_vld[k]) w_vld_nxt[w_clear_idx[k]] = 1'b0;
    end
    w_vld_nxt = w_vld_nxt & ~w_kill;
    if (w_accept) begin
      for (int unsigned i = 0; i < INPORT_NUM; i++) begin
        if (io_bus.i_enq_req[i]) begin
          w_vld_nxt[w_alloc_id[i]]  = 1'b1;
          w_done_nxt[w_alloc_id[i]] = 1'b0;
        end
      end
    end

    w_head_nxt = f_add(r_head, w_clr_num);
    if (io_bus.i_squash_vld) begin
      w_tail_nxt  = io_bus.i_squash_dqIdx;
      w_count_nxt = cnt_t'(w_sq_dist - w_clr_num);
    end else begin
      w_tail_nxt  = w_accept ? f_add(r_tail, w_enq_num) : r_tail;
      w_count_nxt = cnt_t'(32'(r_count) + (w_accept ? w_enq_num : 0) - w_clr_num);
    end

    if (io_bus.i_flush) begin
      w_vld_nxt   = '0;
      w_done_nxt  = '0;
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld   <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_vld   <= w_vld_nxt;
      r_done  <= w_done_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Payload storage carries no reset; validity lives in r_vld.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int unsigned i = 0; i < INPORT_NUM; i++) begin
        if (io_bus.i_enq_req[i]) r_buf[w_alloc_id[i]] <= io_bus.i_enq_data[i];
      end
    end
  end

  assign io_bus.o_can_enq   = w_can_enq;
  assign io_bus.o_clear_vld = w_clear_vld;
  assign io_bus.o_count     = r_count;

  always_comb begin
    for (int unsigned i = 0; i < INPORT_NUM; i++) io_bus.o_alloc_id[i] = w_alloc_id[i];
    for (int unsigned k = 0; k < CLEAR_WID; k++) io_bus.o_clear_dqIdx[k] = w_clear_idx[k];
    for (int unsigned r = 0; r < READPORT_NUM; r++) begin
      io_bus.o_read_data[r] = (32'(io_bus.i_read_dqIdx[r]) < DEPTH)
                              ? r_buf[io_bus.i_read_dqIdx[r]] : '0;
    end
  end
endmodule

// File: tb/tb_data_ring_que.sv
// Directed bench for data_ring_que at DEPTH=6, four enqueue ports, two retire slots.
module tb_data_ring_que;
  localparam int unsigned DEPTH        = 6;
  localparam int unsigned INPORT_NUM   = 4;
  localparam int unsigned READPORT_NUM = 4;
  localparam int unsigned WBPORT_NUM   = 4;
  localparam int unsigned CLEAR_WID    = 2;
  typedef logic [15:0] dtype;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_ring_que_if #(
    .DEPTH(DEPTH), .INPORT_NUM(INPORT_NUM), .READPORT_NUM(READPORT_NUM),
    .WBPORT_NUM(WBPORT_NUM), .CLEAR_WID(CLEAR_WID), .dtype(dtype)
  ) bus ();

  data_ring_que #(
    .DEPTH(DEPTH), .INPORT_NUM(INPORT_NUM), .READPORT_NUM(READPORT_NUM),
    .WBPORT_NUM(WBPORT_NUM), .CLEAR_WID(CLEAR_WID), .dtype(dtype)
  ) u_dut (
    .clk   (clk),
    .rst   (rst_n),
    .io_bus(bus)
  );

  task automatic idle();
    bus.i_enq_req      = '0;
    bus.i_wb_vld       = '0;
    bus.i_squash_vld   = 1'b0;
    bus.i_squash_dqIdx = '0;
    bus.i_flush        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_enq_data[i]   = '0;
      bus.i_read_dqIdx[i] = '0;
      bus.i_wb_dqIdx[i]   = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drive_enq(input logic [3:0] req, input logic [15:0] base);
    bus.i_enq_req = req;
    for (int i = 0; i < 4; i++) bus.i_enq_data[i] = base + 16'(i);
  endtask

  task automatic drive_wb(input logic [3:0] v, input int a, input int b, input int c,
                          input int d);
    bus.i_wb_vld      = v;
    bus.i_wb_dqIdx[0] = 3'(a);
    bus.i_wb_dqIdx[1] = 3'(b);
    bus.i_wb_dqIdx[2] = 3'(c);
    bus.i_wb_dqIdx[3] = 3'(d);
  endtask

  task automatic drive_rd(input int a, input int b, input int c, input int d);
    bus.i_read_dqIdx[0] = 3'(a);
    bus.i_read_dqIdx[1] = 3'(b);
    bus.i_read_dqIdx[2] = 3'(c);
    bus.i_read_dqIdx[3] = 3'(d);
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    bus.i_enq_req = 4'b1111;
    bus.i_flush   = 1'b1;
    #2;
    n_cmp++; if (bus.o_count !== 3'd0) begin
      n_bad++; $display("FAIL reset_count got %0d want 0", bus.o_count); end
    n_cmp++; if (bus.o_can_enq !== 1'b1) begin
      n_bad++; $display("FAIL reset_can_enq got %b want 1", bus.o_can_enq); end
    n_cmp++; if (bus.o_clear_vld !== 2'b00) begin
      n_bad++; $display("FAIL reset_clear_vld got %b want 00", bus.o_clear_vld); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.o_alloc_id[i] !== 3'(i)) begin
        n_bad++; $display("FAIL reset_alloc_id[%0d] got %0d want %0d", i, bus.o_alloc_id[i], i);
      end
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_enq_basic();
    do_reset();
    drive_enq(4'b1011, 16'h00A0);
    #1;
    n_cmp++; if (bus.o_alloc_id[0] !== 3'd0) begin
      n_bad++; $display("FAIL enq_alloc0 got %0d want 0", bus.o_alloc_id[0]); end
    n_cmp++; if (bus.o_alloc_id[1] !== 3'd1) begin
      n_bad++; $display("FAIL enq_alloc1 got %0d want 1", bus.o_alloc_id[1]); end
    n_cmp++; if (bus.o_alloc_id[3] !== 3'd2) begin
      n_bad++; $display("FAIL enq_alloc3 got %0d want 2", bus.o_alloc_id[3]); end
    tick();
    idle();
    drive_rd(0, 1, 2, 0);
    #1;
    n_cmp++; if (bus.o_count !== 3'd3) begin
      n_bad++; $display("FAIL enq_count got %0d want 3", bus.o_count); end
    n_cmp++; if (bus.o_can_enq !== 1'b0) begin
      n_bad++; $display("FAIL enq_can_enq_at_3 got %b want 0", bus.o_can_enq); end
    n_cmp++; if (bus.o_read_data[0] !== 16'h00A0) begin
      n_bad++; $display("FAIL enq_rd0 got %h want 00a0", bus.o_read_data[0]); end
    n_cmp++; if (bus.o_read_data[1] !== 16'h00A1) begin
      n_bad++; $display("FAIL enq_rd1 got %h want 00a1", bus.o_read_data[1]); end
    n_cmp++; if (bus.o_read_data[2] !== 16'h00A3) begin
      n_bad++; $display("FAIL enq_rd2 got %h want 00a3", bus.o_read_data[2]); end
    drive_enq(4'b0001, 16'h0011);
    #1;
    n_cmp++; if (bus.o_alloc_id[0] !== 3'd3) begin
      n_bad++; $display("FAIL enq_tail_probe got %0d want 3", bus.o_alloc_id[0]); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.o_count !== 3'd3) begin
      n_bad++; $display("FAIL enq_blocked_count got %0d want 3", bus.o_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive_enq(4'b1111, 16'h0000);
    tick();
    idle();
    drive_wb(4'b1111, 0, 1, 2, 3);
    tick();
    idle();
    #1;
    n_cmp++; if (bus.o_clear_vld !== 2'b11 || bus.o_clear_dqIdx[0] !== 3'd0
                 || bus.o_clear_dqIdx[1] !== 3'd1) begin
      n_bad++; $display("FAIL wrap_pre_clear_a got %b {%0d,%0d} want 11 {0,1}",
                        bus.o_clear_vld, bus.o_clear_dqIdx[0], bus.o_clear_dqIdx[1]); end
    tick();
    n_cmp++; if (bus.o_clear_vld !== 2'b11 || bus.o_clear_dqIdx[0] !== 3'd2
                 || bus.o_clear_dqIdx[1] !== 3'd3) begin
      n_bad++; $display("FAIL wrap_pre_clear_b got %b {%0d,%0d} want 11 {2,3}",
                        bus.o_clear_vld, bus.o_clear_dqIdx[0], bus.o_clear_dqIdx[1]); end
    tick();
    n_cmp++; if (bus.o_count !== 3'd0) begin
      n_bad++; $display("FAIL wrap_drained_count got %0d want 0", bus.o_count); end
    drive_enq(4'b1111, 16'h00B0);
    #1;
    n_cmp++; if (bus.o_alloc_id[0] !== 3'd4 || bus.o_alloc_id[1] !== 3'd5
                 || bus.o_alloc_id[2] !== 3'd0 || bus.o_alloc_id[3] !== 3'd1) begin
      n_bad++; $display("FAIL wrap_alloc got {%0d,%0d,%0d,%0d} want {4,5,0,1}",
                        bus.o_alloc_id[0], bus.o_alloc_id[1], bus.o_alloc_id[2],
                        bus.o_alloc_id[3]); end
    tick();
    idle();
    drive_rd(4, 5, 0, 1);
    drive_wb(4'b1111, 4, 5, 0, 1);
    #1;
    n_cmp++; if (bus.o_count !== 3'd4) begin
      n_bad++; $display("FAIL wrap_count got %0d want 4", bus.o_count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.o_read_data[i] !== 16'h00B0 + 16'(i)) begin
        n_bad++; $display("FAIL wrap_rd[%0d] got %h want %h", i, bus.o_read_data[i],
                          16'h00B0 + 16'(i)); end
    end
    n_cmp++; if (bus.o_clear_vld !== 2'b00) begin
      n_bad++; $display("FAIL wrap_same_cycle_wb got %b want 00", bus.o_clear_vld); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.o_clear_vld !== 2'b11 || bus.o_clear_dqIdx[0] !== 3'd4
                 || bus.o_clear_dqIdx[1] !== 3'd5) begin
      n_bad++; $display("FAIL wrap_clear_a got %b {%0d,%0d} want 11 {4,5}",
                        bus.o_clear_vld, bus.o_clear_dqIdx[0], bus.o_clear_dqIdx[1]); end
    tick();
    n_cmp++; if (bus.o_clear_vld !== 2'b11 || bus.o_clear_dqIdx[0] !== 3'd0
                 || bus.o_clear_dqIdx[1] !== 3'd1) begin
      n_bad++; $display("FAIL wrap_clear_b got %b {%0d,%0d} want 11 {0,1}",
                        bus.o_clear_vld, bus.o_clear_dqIdx[0], bus.o_clear_dqIdx[1]); end
    tick();
    n_cmp++; if (bus.o_count !== 3'd0 || bus.o_clear_vld !== 2'b00) begin
      n_bad++; $display("FAIL wrap_final got count %0d clr %b want 0 00",
                        bus.o_count, bus.o_clear_vld); end
  endtask

  task automatic test_ooo_wb();
    do_reset();
    drive_enq(4'b1111, 16'h00C0);
    tick();
    idle();
    drive_wb(4'b0011, 1, 2, 0, 0);
    #1;
    n_cmp++; if (bus.o_clear_vld !== 2'b00) begin
      n_bad++; $display("FAIL ooo_clear_a got %b want 00", bus.o_clear_vld); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.o_clear_vld !== 2'b00) begin
      n_bad++; $display("FAIL ooo_head_not_done got %b want 00", bus.o_clear_vld); end
    drive_wb(4'b0001, 0, 0, 0, 0);
    tick();
    idle();
    #1;
    n_cmp++; if (bus.o_clear_vld !== 2'b11 || bus.o_clear_dqIdx[0] !== 3'd0
                 || bus.o_clear_dqIdx[1] !== 3'd1) begin
      n_bad++; $display("FAIL ooo_clear_b got %b {%0d,%0d} want 11 {0,1}",
                        bus.o_clear_vld, bus.o_clear_dqIdx[0], bus.o_clear_dqIdx[1]); end
    tick();
    n_cmp++; if (bus.o_clear_vld !== 2'b01 || bus.o_clear_dqIdx[0] !== 3'd2
                 || bus.o_count !== 3'd2) begin
      n_bad++; $display("FAIL ooo_clear_c got %b idx %0d count %0d want 01 idx 2 count 2",
                        bus.o_clear_vld, bus.o_clear_dqIdx[0], bus.o_count); end
    tick();
    n_cmp++; if (bus.o_count !== 3'd1 || bus.o_clear_vld !== 2'b00) begin
      n_bad++; $display("FAIL ooo_final got count %0d clr %b want 1 00",
                        bus.o_count, bus.o_clear_vld); end
  endtask

  task automatic test_squash();
    do_reset();
    drive_enq(4'b0011, 16'h00D0);
    tick();
    drive_enq(4'b0111, 16'h00D2);
    #1;
    n_cmp++; if (bus.o_alloc_id[0] !== 3'd2 || bus.o_alloc_id[2] !== 3'd4) begin
      n_bad++; $display("FAIL sq_alloc got {%0d,%0d} want {2,4}",
                        bus.o_alloc_id[0], bus.o_alloc_id[2]); end
    tick();
    idle();
    drive_wb(4'b0011, 0, 1, 0, 0);
    #1;
    n_cmp++; if (bus.o_count !== 3'd5) begin
      n_bad++; $display("FAIL sq_setup_count got %0d want 5", bus.o_count); end
    tick();
    idle();
    bus.i_squash_vld   = 1'b1;
    bus.i_squash_dqIdx = 3'd3;
    #1;
    n_cmp++; if (bus.o_clear_vld !== 2'b11 || bus.o_clear_dqIdx[0] !== 3'd0
                 || bus.o_clear_dqIdx[1] !== 3'd1) begin
      n_bad++; $display("FAIL sq_concurrent_clear got %b {%0d,%0d} want 11 {0,1}",
                        bus.o_clear_vld, bus.o_clear_dqIdx[0], bus.o_clear_dqIdx[1]); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.o_count !== 3'd1) begin
      n_bad++; $display("FAIL sq_count got %0d want 1", bus.o_count); end
    bus.i_enq_req = 4'b0001;
    #1;
    n_cmp++; if (bus.o_alloc_id[0] !== 3'd3) begin
      n_bad++; $display("FAIL sq_tail got %0d want 3", bus.o_alloc_id[0]); end
    bus.i_enq_req = 4'b0000;
    drive_rd(2, 0, 0, 0);
    drive_wb(4'b0011, 4, 2, 0, 0);
    #1;
    n_cmp++; if (bus.o_read_data[0] !== 16'h00D2) begin
      n_bad++; $display("FAIL sq_rd2 got %h want 00d2", bus.o_read_data[0]); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.o_clear_vld !== 2'b01 || bus.o_clear_dqIdx[0] !== 3'd2) begin
      n_bad++; $display("FAIL sq_clear_survivor got %b idx %0d want 01 idx 2",
                        bus.o_clear_vld, bus.o_clear_dqIdx[0]); end
    tick();
    drive_enq(4'b0011, 16'h00E0);
    #1;
    n_cmp++; if (bus.o_count !== 3'd0 || bus.o_alloc_id[0] !== 3'd3
                 || bus.o_alloc_id[1] !== 3'd4) begin
      n_bad++; $display("FAIL sq_reuse got count %0d ids {%0d,%0d} want 0 {3,4}",
                        bus.o_count, bus.o_alloc_id[0], bus.o_alloc_id[1]); end
    tick();
    idle();
    drive_wb(4'b0001, 3, 0, 0, 0);
    tick();
    idle();
    #1;
    n_cmp++; if (bus.o_clear_vld !== 2'b01 || bus.o_clear_dqIdx[0] !== 3'd3) begin
      n_bad++; $display("FAIL sq_stale_wb_ignored got %b idx %0d want 01 idx 3",
                        bus.o_clear_vld, bus.o_clear_dqIdx[0]); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_enq(4'b1111, 16'h00F0);
    tick();
    idle();
    drive_wb(4'b1111, 0, 1, 2, 3);
    tick();
    idle();
    bus.i_flush = 1'b1;
    drive_enq(4'b1111, 16'h0070);
    #1;
    n_cmp++; if (bus.o_clear_vld !== 2'b00) begin
      n_bad++; $display("FAIL flush_clear_forced got %b want 00", bus.o_clear_vld); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.o_count !== 3'd0 || bus.o_can_enq !== 1'b1
                 || bus.o_clear_vld !== 2'b00) begin
      n_bad++; $display("FAIL flush_state got count %0d can %b clr %b want 0 1 00",
                        bus.o_count, bus.o_can_enq, bus.o_clear_vld); end
    drive_enq(4'b0001, 16'h0055);
    #1;
    n_cmp++; if (bus.o_alloc_id[0] !== 3'd0) begin
      n_bad++; $display("FAIL flush_tail got %0d want 0", bus.o_alloc_id[0]); end
    tick();
    idle();
    drive_rd(0, 0, 0, 0);
    #1;
    n_cmp++; if (bus.o_count !== 3'd1 || bus.o_read_data[0] !== 16'h0055
                 || bus.o_clear_vld !== 2'b00) begin
      n_bad++; $display("FAIL flush_reuse got count %0d rd %h clr %b want 1 0055 00",
                        bus.o_count, bus.o_read_data[0], bus.o_clear_vld); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_enq(4'b1111, 16'h0010);
    tick();
    idle();
    drive_wb(4'b1111, 0, 1, 2, 3);
    tick();
    idle();
    #1;
    n_cmp++; if (bus.o_count !== 3'd4 || bus.o_clear_vld !== 2'b11) begin
      n_bad++; $display("FAIL arst_pre got count %0d clr %b want 4 11",
                        bus.o_count, bus.o_clear_vld); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_count !== 3'd0 || bus.o_can_enq !== 1'b1
                 || bus.o_clear_vld !== 2'b00) begin
      n_bad++; $display("FAIL arst_now got count %0d can %b clr %b want 0 1 00",
                        bus.o_count, bus.o_can_enq, bus.o_clear_vld); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.o_count !== 3'd0) begin
      n_bad++; $display("FAIL arst_after got count %0d want 0", bus.o_count); end
  endtask

  initial begin
    test_reset();
    test_enq_basic();
    test_wrap();
    test_ooo_wb();
    test_squash();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
